// File: rtl/div_tick_ctrl.sv
// Tap selector, resynchronizer and tick generator for the 18-stage ripple divider.
// Emits one-cycle clock enables on rising edges of the selected tap.
module div_tick_ctrl #(
  parameter int TAPS        = 18,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAPS-1:0]  div_q,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [4:0]       cfg_tap,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic             tap_err
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [4:0]             tap_q, tap_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       rem_q, rem_d;
  logic [7:0]             settle_q, settle_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tap_bit;
  logic                   rise;
  logic                   cfg_bad;
  logic                   counted;
  logic                   finish;
  logic                   tick_d, done_d, err_d;

  assign tap_bit   = div_q[tap_q];
  assign rise      = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign cfg_bad   = cfg_valid && (int'(cfg_tap) >= TAPS);
  assign counted   = (cnt_q != '0);
  // Last counted tick is showing now; leave RUN on the next edge.
  assign finish    = tick && counted && (rem_q == '0);
  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    settle_d = settle_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            tap_d = cfg_tap;
            cnt_d = cfg_count;
          end
        end
        if (start && !cfg_bad) begin
          state_d  = SETTLE;
          settle_d = '0;
          rem_d    = cfg_valid ? cfg_count : cnt_q;
        end
      end
      // Old-tap samples drain out of the chain before RUN looks at it.
      SETTLE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (settle_q == 8'(SYNC_STAGES)) begin
          state_d = RUN;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (finish) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (rise) begin
          tick_d = 1'b1;
          if (counted) rem_d = rem_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tap_q    <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      settle_q <= '0;
      sync_q   <= '0;
      hist_q   <= 1'b0;
      tick     <= 1'b0;
      done     <= 1'b0;
      tap_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      settle_q <= settle_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], tap_bit};
      hist_q   <= sync_q[SYNC_STAGES-1];
      tick     <= tick_d;
      done     <= done_d;
      tap_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_div_tick_ctrl.sv
// Bench for div_tick_ctrl: edge-indexed reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_div_tick_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] div_cnt = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [4:0]  cfg_tap = '0;
  logic [7:0]  cfg_count = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        tick, done, busy, tap_err;

  int checks = 0;
  int failures = 0;

  div_tick_ctrl dut (
    .clk(clk), .rst(rst), .div_q(div_cnt),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_tap(cfg_tap), .cfg_count(cfg_count),
    .start(start), .stop(stop),
    .tick(tick), .done(done), .busy(busy), .tap_err(tap_err)
  );

  initial forever #5 clk = ~clk;

  // Divider model: free-running counter, one step per clk.
  initial forever begin
    @(posedge clk);
    div_cnt <= div_cnt + 18'd1;
  end

  // Reference model, indexed by clock edge number.
  int          ecnt = 0;
  logic [17:0] h0 = '0, h1 = '0, h2 = '0, h3 = '0;
  logic [17:0] off = '0;
  bit          seen_rst = 0;
  bit          m_run = 0, m_pend = 0;
  int          m_b = 0, m_n = 0;
  logic [4:0]  m_tap = '0;
  logic [7:0]  m_cnt = '0;
  bit          x_tick = 0, x_done = 0, x_err = 0;

  initial forever begin
    bit bad;
    @(posedge clk);
    ecnt++;
    h3 = h2; h2 = h1; h1 = h0; h0 = div_cnt;
    off = h0 - 18'(ecnt);
    x_tick = 0; x_done = 0; x_err = 0;
    if (rst) begin
      seen_rst = 1;
      m_run = 0; m_pend = 0; m_tap = '0; m_cnt = '0;
    end else if (!m_run) begin
      bad = cfg_valid && (cfg_tap >= 5'd18);
      if (cfg_valid) begin
        if (bad) x_err = 1;
        else begin m_tap = cfg_tap; m_cnt = cfg_count; end
      end
      if (start && !bad) begin
        m_run = 1; m_b = ecnt; m_n = 0; m_pend = 0;
      end
    end else if (stop) begin
      m_run = 0;
    end else if (m_pend) begin
      m_run = 0; x_done = 1;
    end else if (ecnt >= m_b + 4 && h2[m_tap] && !h3[m_tap]) begin
      // Tap sampled high at edge e-2 after low at e-3 -> tick after edge e.
      x_tick = 1;
      m_n++;
      if (m_cnt != 0 && m_n == int'(m_cnt)) m_pend = 1;
    end
  end

  function automatic logic [17:0] samp(int e);
    return 18'(e) + off;
  endfunction

  task automatic chk(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b required %0b (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  int tq[$];
  int dq[$];
  int eq[$];
  bit dbusy[$];

  // Per-cycle compare against the model plus event recording.
  initial forever begin
    @(negedge clk);
    if (seen_rst) begin
      chk("tick", tick, x_tick);
      chk("done", done, x_done);
      chk("busy", busy, m_run);
      chk("cfg_ready", cfg_ready, !m_run);
      chk("tap_err", tap_err, x_err);
    end
    if (tick === 1'b1) tq.push_back(ecnt);
    if (done === 1'b1) begin dq.push_back(ecnt); dbusy.push_back(busy); end
    if (tap_err === 1'b1) eq.push_back(ecnt);
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearq();
    tq.delete(); dq.delete(); eq.delete(); dbusy.delete();
  endtask

  task automatic cfg(int tap, int cnt, bit st);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_tap = 5'(tap); cfg_count = 8'(cnt); start = st;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
  endtask

  task automatic go();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop(output int s);
    @(negedge clk); stop = 1'b1; s = ecnt + 1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic wait_idle(int lim, string nm);
    int k = 0;
    while (busy !== 1'b0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s: timeout busy=%0b required 0", nm, busy);
    end
  endtask

  function automatic int bad_gaps(int gap);
    int n = 0;
    for (int i = 1; i < tq.size(); i++)
      if (tq[i] - tq[i-1] != gap) n++;
    return n;
  endfunction

  initial begin
    int s, b, late, nrise;
    int tap, cnt, mode, w;

    // Reset state
    cycles(3);
    chk("rst_tick", tick, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_err", tap_err, 1'b0);
    rst = 1'b0;
    cycles(2);

    // 1: tap 3, count 4
    clearq();
    cfg(3, 4, 0);
    go();
    wait_idle(200, "t1_idle");
    chk_int("t1_nticks", tq.size(), 4);
    chk_int("t1_gaps16", bad_gaps(16), 0);
    chk_int("t1_ndone", dq.size(), 1);
    if (tq.size() == 4 && dq.size() == 1) begin
      chk_int("t1_done_pos", dq[0], tq[3] + 1);
      chk("t1_done_busy", dbusy[0], 1'b0);
    end

    // 2: tap 0 continuous, stop after 20 cycles
    clearq();
    cfg(0, 0, 0);
    go();
    cycles(20);
    pulse_stop(s);
    cycles(3);
    #1;
    chk_int("t2_gaps2", bad_gaps(2), 0);
    chk("t2_enough", tq.size() >= 8, 1'b1);
    late = 0;
    foreach (tq[i]) if (tq[i] >= s) late++;
    chk_int("t2_late", late, 0);
    chk_int("t2_ndone", dq.size(), 0);
    chk("t2_busy", busy, 1'b0);

    // 3: bad tap keeps previous tap 5 / count 2
    cfg(5, 2, 0);
    clearq();
    cfg(18, 1, 0);
    #1;
    chk_int("t3_err1", eq.size(), 1);
    cycles(2);
    #1;
    chk_int("t3_errw", eq.size(), 1);
    go();
    wait_idle(400, "t3_idle");
    chk_int("t3_nticks", tq.size(), 2);
    chk_int("t3_gaps64", bad_gaps(64), 0);

    // 4: config + start together, mid-run offer ignored
    clearq();
    @(negedge clk);
    cfg_valid = 1'b1; cfg_tap = 5'd2; cfg_count = 8'd3; start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    cycles(6);
    cfg_valid = 1'b1; cfg_tap = 5'd7; cfg_count = 8'd1;
    @(negedge clk);
    chk("t4_ready0", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    wait_idle(200, "t4_idle");
    chk_int("t4_nticks", tq.size(), 3);
    chk_int("t4_gaps8", bad_gaps(8), 0);

    // 5: reset mid-run
    cfg(1, 10, 0);
    go();
    cycles(8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_tick", tick, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_ready", cfg_ready, 1'b1);
    clearq();
    go();
    cycles(14);
    pulse_stop(s);
    cycles(2);
    #1;
    chk("t5_enough", tq.size() >= 4, 1'b1);
    chk_int("t5_gaps2", bad_gaps(2), 0);
    chk_int("t5_ndone", dq.size(), 0);

    // 6: switch to tap 6 while tap 0 high
    cycles(1);
    w = 0;
    while (!div_cnt[0] && w < 4) begin @(negedge clk); w++; end
    clearq();
    cfg_valid = 1'b1; cfg_tap = 5'd6; cfg_count = 8'd1; start = 1'b1;
    b = ecnt + 1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    wait_idle(300, "t6_idle");
    chk_int("t6_nticks", tq.size(), 1);
    if (tq.size() == 1) begin
      chk("t6_settle", tq[0] >= b + 4, 1'b1);
      chk("t6_rise", samp(tq[0]-2)[6] && !samp(tq[0]-3)[6], 1'b1);
      nrise = 0;
      for (int e = b + 2; e < tq[0] - 2; e++)
        if (samp(e)[6] && !samp(e-1)[6]) nrise++;
      chk_int("t6_first", nrise, 0);
    end

    // Randomized phase, checked by the per-cycle model compare
    for (int it = 0; it < 40; it++) begin
      tap  = ($urandom_range(0, 7) == 0) ? $urandom_range(18, 31) : $urandom_range(0, 3);
      cnt  = $urandom_range(0, 4);
      mode = $urandom_range(0, 1);
      if (mode == 0) cfg(tap, cnt, 1);
      else begin cfg(tap, cnt, 0); go(); end
      w = $urandom_range(0, 100);
      for (int k = 0; k < w; k++) begin
        @(negedge clk);
        cfg_valid = ($urandom_range(0, 15) == 0);
        cfg_tap   = 5'($urandom_range(0, 3));
        cfg_count = 8'($urandom_range(0, 4));
      end
      @(negedge clk);
      cfg_valid = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        pulse_stop(s);
      end
      wait_idle(10, "rnd_idle");
      cycles($urandom_range(0, 3));
    end

    cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_tick_ctrl.md
# div_tick_ctrl

Controller for the 18-stage ripple frequency divider. It takes the divider's 18 tap outputs, selects one tap under a configuration handshake, and resynchronizes it into the system clock domain. It emits single-cycle `tick` enables on each rising edge of that tap, either for a programmed number of ticks or continuously. Downstream logic uses `tick` as a clock enable, never as a clock.

## Interface
Parameters:
- `TAPS`, 18: number of divider taps on `div_q`.
- `CNT_W`, 8: width of the tick-count field.
- `SYNC_STAGES`, 2: synchronizer flops per tap path (minimum 2).

Ports:
- `clk`  in  1: system clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `div_q`  in  TAPS: divider tap outputs, asynchronous to `clk`; bit 0 is the fastest tap.
- `cfg_valid`  in  1: configuration offer.
- `cfg_ready`  out  1: configuration accepted when `cfg_valid` and `cfg_ready` are both high.
- `cfg_tap`  in  5: tap index to select.
- `cfg_count`  in  CNT_W: number of ticks per run; 0 means continuous.
- `start`  in  1: begin a run (IDLE only).
- `stop`  in  1: abort a run.
- `tick`  out  1: one-cycle enable per selected-tap rising edge.
- `done`  out  1: one-cycle pulse when a counted run completes.
- `busy`  out  1: high in any state other than IDLE.
- `tap_err`  out  1: one-cycle pulse when a configuration is rejected.

## Operation
- Reset values:
  - State is IDLE.
  - `tick`, `done` and `tap_err` are 0.
  - `busy` is 0.
  - `cfg_ready` is 1.
  - Stored tap is 0 and stored count is 0.
  - Synchronizer and edge-history flops are 0.
- Configuration:
  - Accepted only in IDLE, when `cfg_ready` is 1.
  - A `cfg_tap` value of `TAPS` or more is rejected. `tap_err` pulses the next cycle and the stored config is unchanged.
  - Otherwise `cfg_tap` and `cfg_count` are stored.
  - `cfg_ready` is 0 in every non-IDLE state, and `cfg_valid` is ignored there.
- Tap path: the mux selects the stored tap. Its output feeds a `SYNC_STAGES` flop chain and then one history flop. An edge is detected when the synchronized value is 1 and the history flop is 0.
- State machine:
  - IDLE -> SETTLE on `start`. If `cfg_valid` and `start` arrive together, the new config is captured and used for that run. An invalid tap in that cycle suppresses the start, and the block stays in IDLE.
  - SETTLE lasts `SYNC_STAGES` + 1 cycles to flush the synchronizer and history flops, so no edge from the previous tap is reported. `tick` is held at 0. SETTLE -> RUN when the flush completes.
  - RUN: `tick` <= edge AND NOT `stop`. The remaining counter is loaded from the stored count on entry to SETTLE and decrements on each emitted tick.
  - RUN -> IDLE after the tick that moves remaining from 1 to 0. `done` pulses in the first IDLE cycle.
  - With count 0, RUN continues until `stop`.
  - `stop` in SETTLE or RUN -> IDLE the next cycle. No `done` is raised, and a tick coincident with `stop` is suppressed because stop has priority.
  - `start` outside IDLE is ignored.
- `busy` is low in the same cycle that `done` is high.
- `rst` during a run returns the block to the reset values on the next edge. No `tick` or `done` is emitted after that.

## Timing
- Latency: the tap is first sampled high at clock edge k, and `tick` is high for the cycle following edge k + `SYNC_STAGES`. With the default parameters this is 3 cycles.
- `tick` is exactly 1 cycle wide. Tap 0 produces a tick at most every 2 cycles, and tap n produces a tick every 2^(n+1) cycles in steady state.
- From `start` to the first possible `tick` is `SYNC_STAGES` + 2 cycles.
- `tap_err` and `done` are registered outputs, 1 cycle wide.
- Handshake: config takes effect on the cycle after acceptance, and the `cfg_*` inputs are not used after that.

## Test plan
- Bench divider model: an 18-bit counter incremented every `clk`, driving `div_q`.
1. Reset, then configure tap 3 with count 4, then start -> exactly 4 ticks spaced 16 cycles apart, `done` in the cycle after the 4th tick, `busy` low in that same cycle.
2. Configure tap 0 with count 0, then start, then `stop` after 20 cycles -> a tick every 2 cycles, no tick in or after the stop cycle, `done` never asserted.
3. Configure with `cfg_tap`=18 -> `tap_err` for 1 cycle. A following start uses the previous tap of 5, giving ticks every 64 cycles.
4. Drive `cfg_valid` with tap 2 and `start` in the same cycle -> the run uses tap 2, giving ticks every 8 cycles. `cfg_ready` is 0 throughout the run, and a tap 7 offer mid-run is ignored.
5. Assert `rst` mid-run on tap 1 with count 10 -> `tick`, `done` and `busy` are 0 the next cycle and `cfg_ready` is 1. Stored config is tap 0 with count 0.
6. Switch from tap 0 to tap 6 while `div_q[0]` is high -> no spurious tick during SETTLE. The first tick follows the first tap 6 rising edge with 3-cycle latency.
